// File: rtl/dsp_stq_alloc_ctrl.sv
// Store-queue ID allocator for dispatch: hands out in-order store-buffer IDs and
// tracks alloc/commit/release pointers with wrap bits, with flush rollback.
module dsp_stq_alloc_ctrl #(
    parameter int DEPTH = 32,
    parameter int DSP_W = 4,
    parameter int CMT_W = 2,
    parameter int REL_W = 4,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DSP_W-1:0]              i_dsp_stq_req_vld,
    input  logic                          i_dsp_stq_stall,
    output logic                          o_dsp_stq_alloc_ok,
    output logic [DSP_W*(ID_W+1)-1:0]     o_dsp_stq_req_sbuff_id,
    input  logic [$clog2(CMT_W+1)-1:0]    i_rob_cmt_num,
    input  logic [REL_W-1:0]              i_sbuff_rel_vld,
    input  logic                          i_exu_mis_flush,
    input  logic                          i_rob_mis_st_vld,
    input  logic [ID_W:0]                 i_rob_mis_st_id,
    input  logic                          i_csr_trap_flush,
    output logic [ID_W:0]                 o_stq_alloc_ptr,
    output logic [ID_W:0]                 o_stq_cmt_ptr,
    output logic [ID_W:0]                 o_stq_rel_ptr,
    output logic [ID_W:0]                 o_stq_free_cnt,
    output logic                          o_stq_full,
    output logic                          o_stq_empty,
    output logic                          o_stq_recover
);

    localparam int PW    = ID_W + 1;
    localparam int RQ_W  = $clog2(DSP_W + 1);
    localparam int RL_W  = $clog2(REL_W + 1);
    localparam int CMP_W = (RQ_W > PW) ? RQ_W : PW;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   alloc_q, alloc_d;
    logic [PW-1:0]   cmt_q, cmt_d;
    logic [PW-1:0]   rel_q, rel_d;
    logic [PW-1:0]   occ, free_cnt;
    logic [RQ_W-1:0] nreq, lane_rank;
    logic [RL_W-1:0] nrel;
    logic            mis_flush, alloc_ok, do_alloc;

    always_comb begin
        nreq = '0;
        for (int k = 0; k < DSP_W; k++) nreq = nreq + RQ_W'(i_dsp_stq_req_vld[k]);
        nrel = '0;
        for (int k = 0; k < REL_W; k++) nrel = nrel + RL_W'(i_sbuff_rel_vld[k]);
    end

    // Each lane gets the alloc pointer plus its rank among the requesting lanes below it.
    always_comb begin
        o_dsp_stq_req_sbuff_id = '0;
        lane_rank              = '0;
        for (int k = 0; k < DSP_W; k++) begin
            o_dsp_stq_req_sbuff_id[k*PW +: PW] = alloc_q + PW'(lane_rank);
            lane_rank = lane_rank + RQ_W'(i_dsp_stq_req_vld[k]);
        end
    end

    // Occupancy from the wrap-bit pointers lets all DEPTH entries be used.
    assign occ       = alloc_q - rel_q;
    assign free_cnt  = PW'(DEPTH) - occ;
    assign mis_flush = i_exu_mis_flush & i_rob_mis_st_vld;
    assign alloc_ok  = (state_q == ST_RUN) & (CMP_W'(free_cnt) >= CMP_W'(nreq))
                       & ~i_csr_trap_flush & ~mis_flush;
    assign do_alloc  = (nreq != '0) & alloc_ok & ~i_dsp_stq_stall;
    assign cmt_d     = cmt_q + PW'(i_rob_cmt_num);
    assign rel_d     = rel_q + PW'(nrel);

    // Trap rolls back to the post-commit point and outranks a mispredict rollback.
    always_comb begin
        alloc_d = alloc_q;
        state_d = ST_RUN;
        if (i_csr_trap_flush) begin
            alloc_d = cmt_d;
            state_d = ST_RECOVER;
        end else if (mis_flush) begin
            alloc_d = i_rob_mis_st_id;
            state_d = ST_RECOVER;
        end else if (do_alloc) begin
            alloc_d = alloc_q + PW'(nreq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            alloc_q <= '0;
            cmt_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            alloc_q <= alloc_d;
            cmt_q   <= cmt_d;
            rel_q   <= rel_d;
        end
    end

    assign o_dsp_stq_alloc_ok = alloc_ok;
    assign o_stq_alloc_ptr    = alloc_q;
    assign o_stq_cmt_ptr      = cmt_q;
    assign o_stq_rel_ptr      = rel_q;
    assign o_stq_free_cnt     = free_cnt;
    assign o_stq_full         = (free_cnt == '0);
    assign o_stq_empty        = (alloc_q == rel_q);
    assign o_stq_recover      = (state_q == ST_RECOVER);

endmodule

// File: tb/tb_dsp_stq_alloc_ctrl.sv
// Bench for dsp_stq_alloc_ctrl: directed scenarios plus random legal traffic
// checked against an unbounded-integer model of the three pointers.
module tb_dsp_stq_alloc_ctrl;

    localparam int DEPTH = 32;
    localparam int DSP_W = 4;
    localparam int CMT_W = 2;
    localparam int REL_W = 4;
    localparam int ID_W  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        stall;
    logic [1:0]  cmt_num;
    logic [3:0]  rel_vld;
    logic        mis, mis_vld, trap;
    logic [5:0]  mis_id;
    logic        alloc_ok;
    logic [23:0] ids;
    logic [5:0]  alloc_ptr, cmt_ptr, rel_ptr, free_cnt;
    logic        full, empty, recover;

    int checks   = 0;
    int failures = 0;
    int mis_abs;
    int m_alloc, m_cmt, m_rel;
    bit m_rec;

    always #5 clk = ~clk;

    dsp_stq_alloc_ctrl #(
        .DEPTH(DEPTH), .DSP_W(DSP_W), .CMT_W(CMT_W), .REL_W(REL_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_dsp_stq_req_vld(req), .i_dsp_stq_stall(stall),
        .o_dsp_stq_alloc_ok(alloc_ok), .o_dsp_stq_req_sbuff_id(ids),
        .i_rob_cmt_num(cmt_num), .i_sbuff_rel_vld(rel_vld),
        .i_exu_mis_flush(mis), .i_rob_mis_st_vld(mis_vld), .i_rob_mis_st_id(mis_id),
        .i_csr_trap_flush(trap),
        .o_stq_alloc_ptr(alloc_ptr), .o_stq_cmt_ptr(cmt_ptr), .o_stq_rel_ptr(rel_ptr),
        .o_stq_free_cnt(free_cnt), .o_stq_full(full), .o_stq_empty(empty),
        .o_stq_recover(recover)
    );

    // Model pointers are plain integers that never wrap; the DUT view is the low 6 bits.
    function automatic int popc4(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int m_free();
        return DEPTH - (m_alloc - m_rel);
    endfunction

    function automatic bit m_grant_ok();
        return !m_rec && (m_free() >= popc4(req)) && !trap && !(mis && mis_vld);
    endfunction

    function automatic int lane_rank(input int k);
        int c = 0;
        for (int i = 0; i < k; i++) c += int'(req[i]);
        return c;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; req = '0; stall = 1'b0; cmt_num = '0; rel_vld = '0;
        mis = 1'b0; mis_vld = 1'b0; trap = 1'b0; mis_abs = 0; mis_id = '0;
    endtask

    task automatic set_mis(input int abs_id);
        mis_abs = abs_id;
        mis_id  = 6'(abs_id);
    endtask

    // One clock edge; the model advances from the inputs as they stood before the edge.
    task automatic cycle();
        int nc, nr, na;
        bit nrec;
        nc = m_cmt + int'(cmt_num);
        nr = m_rel + popc4(rel_vld);
        na = m_alloc;
        nrec = 1'b0;
        if (rst) begin
            na = 0; nc = 0; nr = 0;
        end else begin
            assert (nc <= m_alloc) else $error("[TB] illegal commit stimulus");
            assert (nr <= m_cmt) else $error("[TB] illegal release stimulus");
            if (trap) begin
                na = nc; nrec = 1'b1;
            end else if (mis && mis_vld) begin
                assert (mis_abs >= nc && mis_abs <= m_alloc) else $error("[TB] illegal rollback id");
                na = mis_abs; nrec = 1'b1;
            end else if (m_grant_ok() && popc4(req) != 0 && !stall) begin
                na = m_alloc + popc4(req);
            end
        end
        @(posedge clk);
        #1;
        m_alloc = na; m_cmt = nc; m_rel = nr; m_rec = nrec;
    endtask

    task automatic applyStimulus_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Steers the model and DUT to absolute targets using only legal traffic.
    task automatic drive_to(input int ta, input int tc, input int tr);
        int n, c, r, budget;
        budget = 400;
        idle_inputs();
        while (!(m_alloc == ta && m_cmt == tc && m_rel == tr) && budget > 0) begin
            n = ta - m_alloc;
            if (n > 4) n = 4;
            if (n > m_free()) n = m_free();
            if (n < 0) n = 0;
            c = ((tc < m_alloc) ? tc : m_alloc) - m_cmt;
            if (c > 2) c = 2;
            if (c < 0) c = 0;
            r = ((tr < m_cmt) ? tr : m_cmt) - m_rel;
            if (r > 4) r = 4;
            if (r < 0) r = 0;
            req = 4'((1 << n) - 1);
            cmt_num = 2'(c);
            rel_vld = 4'((1 << r) - 1);
            cycle();
            budget--;
        end
        idle_inputs();
        checks++;
        if (budget == 0) begin
            failures++;
            $display("[TB] FAIL drive_to_budget got alloc=%0d cmt=%0d rel=%0d want %0d/%0d/%0d",
                     m_alloc, m_cmt, m_rel, ta, tc, tr);
        end
    endtask

    task automatic test_reset();
        applyStimulus_reset();
        #1;
        checks++; if (alloc_ptr !== 6'd0) begin failures++; $display("[TB] FAIL reset_alloc got=%0d exp=0", alloc_ptr); end
        checks++; if (cmt_ptr !== 6'd0) begin failures++; $display("[TB] FAIL reset_cmt got=%0d exp=0", cmt_ptr); end
        checks++; if (rel_ptr !== 6'd0) begin failures++; $display("[TB] FAIL reset_rel got=%0d exp=0", rel_ptr); end
        checks++; if (free_cnt !== 6'd32) begin failures++; $display("[TB] FAIL reset_free got=%0d exp=32", free_cnt); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        checks++; if (recover !== 1'b0) begin failures++; $display("[TB] FAIL reset_recover got=%b exp=0", recover); end
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL reset_alloc_ok got=%b exp=1", alloc_ok); end
    endtask

    task automatic test_basic_grant();
        req = 4'b1011;
        #1;
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL basic_ok got=%b exp=1", alloc_ok); end
        checks++; if (ids[0 +: 6] !== 6'd0) begin failures++; $display("[TB] FAIL basic_lane0 got=%0d exp=0", ids[0 +: 6]); end
        checks++; if (ids[6 +: 6] !== 6'd1) begin failures++; $display("[TB] FAIL basic_lane1 got=%0d exp=1", ids[6 +: 6]); end
        checks++; if (ids[18 +: 6] !== 6'd2) begin failures++; $display("[TB] FAIL basic_lane3 got=%0d exp=2", ids[18 +: 6]); end
        cycle();
        req = '0;
        checks++; if (alloc_ptr !== 6'd3) begin failures++; $display("[TB] FAIL basic_alloc got=%0d exp=3", alloc_ptr); end
        checks++; if (free_cnt !== 6'd29) begin failures++; $display("[TB] FAIL basic_free got=%0d exp=29", free_cnt); end
    endtask

    task automatic test_fill_full();
        drive_to(30, 0, 0);
        req = 4'b1111;
        #1;
        checks++; if (alloc_ok !== 1'b0) begin failures++; $display("[TB] FAIL fill_no_grant got=%b exp=0", alloc_ok); end
        cmt_num = 2'd2;
        cycle();
        req = '0; cmt_num = '0; rel_vld = 4'b0101;
        cycle();
        rel_vld = '0;
        checks++; if (free_cnt !== 6'd4) begin failures++; $display("[TB] FAIL fill_free_after_rel got=%0d exp=4", free_cnt); end
        req = 4'b1111;
        #1;
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL fill_ok got=%b exp=1", alloc_ok); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ids[k*6 +: 6] !== 6'(30 + k)) begin
                failures++; $display("[TB] FAIL fill_lane%0d got=%0d exp=%0d", k, ids[k*6 +: 6], 30 + k);
            end
        end
        cycle();
        req = '0;
        checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%b exp=1", full); end
        checks++; if (alloc_ptr !== 6'd34) begin failures++; $display("[TB] FAIL fill_alloc got=%0d exp=34", alloc_ptr); end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_ids [4];
        exp_ids[0] = 6'd62; exp_ids[1] = 6'd63; exp_ids[2] = 6'd0; exp_ids[3] = 6'd1;
        drive_to(62, 62, 62);
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty); end
        req = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ids[k*6 +: 6] !== exp_ids[k]) begin
                failures++; $display("[TB] FAIL wrap_lane%0d got=%0d exp=%0d", k, ids[k*6 +: 6], exp_ids[k]);
            end
        end
        cycle();
        req = '0;
        checks++; if (alloc_ptr !== 6'd2) begin failures++; $display("[TB] FAIL wrap_alloc got=%0d exp=2", alloc_ptr); end
        checks++; if (free_cnt !== 6'd28) begin failures++; $display("[TB] FAIL wrap_free got=%0d exp=28", free_cnt); end
    endtask

    task automatic test_stall();
        stall = 1'b1; req = 4'b0111;
        #1;
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL stall_ok got=%b exp=1", alloc_ok); end
        cycle();
        checks++; if (alloc_ptr !== 6'd2) begin failures++; $display("[TB] FAIL stall_hold got=%0d exp=2", alloc_ptr); end
        idle_inputs();
    endtask

    task automatic test_mispredict();
        applyStimulus_reset();
        drive_to(20, 8, 4);
        req = 4'b0011; mis = 1'b1; mis_vld = 1'b1; set_mis(12);
        #1;
        checks++; if (alloc_ok !== 1'b0) begin failures++; $display("[TB] FAIL mis_ok got=%b exp=0", alloc_ok); end
        cycle();
        mis = 1'b0; mis_vld = 1'b0;
        checks++; if (alloc_ptr !== 6'd12) begin failures++; $display("[TB] FAIL mis_alloc got=%0d exp=12", alloc_ptr); end
        checks++; if (recover !== 1'b1) begin failures++; $display("[TB] FAIL mis_recover got=%b exp=1", recover); end
        #1;
        checks++; if (alloc_ok !== 1'b0) begin failures++; $display("[TB] FAIL mis_blackout got=%b exp=0", alloc_ok); end
        checks++; if (ids[6 +: 6] !== 6'd13) begin failures++; $display("[TB] FAIL mis_lane1 got=%0d exp=13", ids[6 +: 6]); end
        cycle();
        checks++; if (alloc_ptr !== 6'd12) begin failures++; $display("[TB] FAIL mis_no_grant got=%0d exp=12", alloc_ptr); end
        checks++; if (recover !== 1'b0) begin failures++; $display("[TB] FAIL mis_run got=%b exp=0", recover); end
        #1;
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL mis_ok_again got=%b exp=1", alloc_ok); end
        req = 4'b0001; mis = 1'b1; mis_vld = 1'b0; set_mis(0);
        #1;
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL unq_mis_ok got=%b exp=1", alloc_ok); end
        cycle();
        idle_inputs();
        checks++; if (alloc_ptr !== 6'd13) begin failures++; $display("[TB] FAIL unq_mis_alloc got=%0d exp=13", alloc_ptr); end
        checks++; if (recover !== 1'b0) begin failures++; $display("[TB] FAIL unq_mis_recover got=%b exp=0", recover); end
    endtask

    task automatic test_trap();
        applyStimulus_reset();
        drive_to(20, 8, 4);
        trap = 1'b1; cmt_num = 2'd2; mis = 1'b1; mis_vld = 1'b1; set_mis(15); req = 4'b1111;
        #1;
        checks++; if (alloc_ok !== 1'b0) begin failures++; $display("[TB] FAIL trap_ok got=%b exp=0", alloc_ok); end
        cycle();
        idle_inputs();
        checks++; if (alloc_ptr !== 6'd10) begin failures++; $display("[TB] FAIL trap_alloc got=%0d exp=10", alloc_ptr); end
        checks++; if (cmt_ptr !== 6'd10) begin failures++; $display("[TB] FAIL trap_cmt got=%0d exp=10", cmt_ptr); end
        checks++; if (rel_ptr !== 6'd4) begin failures++; $display("[TB] FAIL trap_rel got=%0d exp=4", rel_ptr); end
        checks++; if (recover !== 1'b1) begin failures++; $display("[TB] FAIL trap_recover got=%b exp=1", recover); end
    endtask

    task automatic test_random();
        int c, r, nc, roll, rot;
        logic [3:0] pat;
        applyStimulus_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            req = 4'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            c = $urandom_range(0, 2);
            if (c > m_alloc - m_cmt) c = m_alloc - m_cmt;
            cmt_num = 2'(c);
            r = $urandom_range(0, 4);
            if (r > m_cmt - m_rel) r = m_cmt - m_rel;
            pat = 4'((1 << r) - 1);
            rot = $urandom_range(0, 3);
            rel_vld = 4'({pat, pat} >> rot);
            roll = $urandom_range(0, 15);
            trap = (roll == 0);
            mis = (roll == 1 || roll == 2);
            mis_vld = (roll == 1);
            nc = m_cmt + c;
            set_mis(nc + $urandom_range(0, m_alloc - nc));
            #1;
            checks++;
            if (alloc_ok !== m_grant_ok()) begin
                failures++; $display("[TB] FAIL rand_ok cyc=%0d got=%b exp=%b", cyc, alloc_ok, m_grant_ok());
            end
            for (int k = 0; k < 4; k++) begin
                if (req[k]) begin
                    checks++;
                    if (ids[k*6 +: 6] !== 6'(m_alloc + lane_rank(k))) begin
                        failures++; $display("[TB] FAIL rand_lane%0d cyc=%0d got=%0d exp=%0d",
                                             k, cyc, ids[k*6 +: 6], 6'(m_alloc + lane_rank(k)));
                    end
                end
            end
            cycle();
            checks++; if (alloc_ptr !== 6'(m_alloc)) begin failures++; $display("[TB] FAIL rand_alloc cyc=%0d got=%0d exp=%0d", cyc, alloc_ptr, 6'(m_alloc)); end
            checks++; if (cmt_ptr !== 6'(m_cmt)) begin failures++; $display("[TB] FAIL rand_cmt cyc=%0d got=%0d exp=%0d", cyc, cmt_ptr, 6'(m_cmt)); end
            checks++; if (rel_ptr !== 6'(m_rel)) begin failures++; $display("[TB] FAIL rand_rel cyc=%0d got=%0d exp=%0d", cyc, rel_ptr, 6'(m_rel)); end
            checks++; if (free_cnt !== 6'(m_free())) begin failures++; $display("[TB] FAIL rand_free cyc=%0d got=%0d exp=%0d", cyc, free_cnt, m_free()); end
            checks++; if (full !== (m_free() == 0)) begin failures++; $display("[TB] FAIL rand_full cyc=%0d got=%b", cyc, full); end
            checks++; if (empty !== (m_alloc == m_rel)) begin failures++; $display("[TB] FAIL rand_empty cyc=%0d got=%b", cyc, empty); end
            checks++; if (recover !== m_rec) begin failures++; $display("[TB] FAIL rand_recover cyc=%0d got=%b exp=%b", cyc, recover, m_rec); end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        applyStimulus_reset();
        drive_to(10, 5, 2);
        trap = 1'b1; mis = 1'b1; mis_vld = 1'b1; set_mis(6); req = 4'b1111; rel_vld = 4'b0001;
        rst = 1'b1;
        cycle();
        idle_inputs();
        checks++; if (alloc_ptr !== 6'd0) begin failures++; $display("[TB] FAIL mrst_alloc got=%0d exp=0", alloc_ptr); end
        checks++; if (cmt_ptr !== 6'd0) begin failures++; $display("[TB] FAIL mrst_cmt got=%0d exp=0", cmt_ptr); end
        checks++; if (rel_ptr !== 6'd0) begin failures++; $display("[TB] FAIL mrst_rel got=%0d exp=0", rel_ptr); end
        checks++; if (free_cnt !== 6'd32) begin failures++; $display("[TB] FAIL mrst_free got=%0d exp=32", free_cnt); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL mrst_empty got=%b exp=1", empty); end
        checks++; if (recover !== 1'b0) begin failures++; $display("[TB] FAIL mrst_recover got=%b exp=0", recover); end
        #1;
        checks++; if (alloc_ok !== 1'b1) begin failures++; $display("[TB] FAIL mrst_ok got=%b exp=1", alloc_ok); end
    endtask

    initial begin
        m_alloc = 0; m_cmt = 0; m_rel = 0; m_rec = 1'b0;
        test_reset();
        test_basic_grant();
        test_fill_full();
        test_wrap();
        test_stall();
        test_mispredict();
        test_trap();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
